dsec_mem_sequencer: RTL
=======================

// Module: dsec_mem_sequencer
// PURPOSE
//  Parametrised memory sequencer between the DSEC core and the word-addressed memory controller.
//  Fetches source words from a read ring (RD_BASE..RD_LIMIT) and feeds them to DSEC.
//  Stores DSEC results into a write ring (WR_BASE..WR_LIMIT).
//  Adds the following:
//   - a source word budget
//   - write-region full/overflow handling
//   - selectable arbitration
//   - a memory-handshake timeout
// PARAMETERS
//  ADDR_W   13       memory address width
//  RD_BASE  0        first read-region address
//  RD_LIMIT 4095     last read-region address (inclusive)
//  WR_BASE  4096     first write-region address
//  WR_LIMIT 8191     last write-region address (inclusive)
//  WR_WRAP  0        1: write pointer wraps WR_LIMIT->WR_BASE; 0: saturate, raise wr_full
//  ARB_RR   0        0: write always wins a tie; 1: tie goes to opposite of last grant
//  TIMEOUT  255      max WAIT cycles for mem_done before abort (>=2)
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       synchronous reset, active-high
//  clr            in   1       synchronous pointer/flag clear, honoured only in IDLE
//  src_words      in   ADDR_W+1  number of source words to read, sampled every IDLE cycle
//  address        out  ADDR_W  memory address
//  w_rn           out  1       1 = write, 0 = read
//  go             out  1       one-cycle memory request strobe
//  mem_done       in   1       memory access complete
//  dsec_rdy       in   1       DSEC can accept a source word
//  dsec_in_valid  out  1       one-cycle pulse: read word on memory bus is for DSEC
//  dsec_out_valid in   1       DSEC holds a result word to store
//  dsec_out_ack   out  1       one-cycle pulse: result stored (or dropped); DSEC may advance
//  rd_done        out  1       rd_cnt == src_words
//  wr_full        out  1       write region exhausted (WR_WRAP=0 only)
//  wr_ovf         out  1       sticky: result dropped while wr_full
//  timeout_err    out  1       sticky: mem_done not seen within TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; rd_ptr=RD_BASE; wr_ptr=WR_BASE; rd_cnt=0; timeout counter 0.
//  All outputs are registered.
//  States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
//  IDLE
//   - wr_req = dsec_out_valid & ~wr_full.
//   - rd_req = dsec_rdy & ~rd_done.
//   - Arbitration per ARB_RR; lone request is granted; the grant enters *_REQ on the next cycle.
//   - dsec_out_valid & wr_full: stay IDLE, set wr_ovf, pulse dsec_out_ack next cycle. No memory access.
//  *_REQ: exactly one cycle.
//   - go=1; w_rn set; address=rd_ptr or wr_ptr.
//   - Next state is *_WAIT.
//  *_WAIT
//   - go=0; address and w_rn held.
//   - Timeout counter increments each WAIT cycle.
//   - mem_done is sampled only in WAIT; it is ignored in IDLE/REQ.
//  WAIT + mem_done
//   - Go to IDLE; clear the counter.
//   - Read: rd_ptr advances, rd_cnt++, dsec_in_valid=1 for the first IDLE cycle.
//   - Write: wr_ptr advances, dsec_out_ack=1 for the first IDLE cycle.
//  WAIT, counter reaches TIMEOUT-1 without mem_done
//   - Go to IDLE; set timeout_err.
//   - Pointers unchanged; no dsec pulse. The same access is retried on the next grant.
//  Pointer rules
//   - rd_ptr wraps RD_LIMIT->RD_BASE.
//   - WR_WRAP=1: wr_ptr wraps, and wr_full stays 0.
//   - WR_WRAP=0: completing a write at WR_LIMIT sets wr_full, and wr_ptr stays at WR_LIMIT.
//  rd_cnt
//   - Width ADDR_W+1; it never exceeds src_words.
//   - src_words=0 makes rd_done=1 immediately.
//  IDLE address/w_rn
//   - address=0 and w_rn=0 in IDLE.
//   - Minimum access = 4 cycles (IDLE, REQ, WAIT, IDLE) with mem_done in the first WAIT cycle.
//  clr in IDLE: restores pointers, rd_cnt, wr_full, wr_ovf and timeout_err to reset values. It has no effect in other states.
//  rst mid-access: immediate return to reset values; the in-flight access is abandoned and go is never re-asserted for it.
// TESTING
//  1. src_words=3, dsec_rdy=1, mem_done one cycle into WAIT -> reads at 0,1,2, three dsec_in_valid pulses, then rd_done=1 and no further go.
//  2. dsec_out_valid and dsec_rdy high together, ARB_RR=0 -> write to 4096 first. With ARB_RR=1 and last grant a write -> read goes first.
//  3. WR_LIMIT=WR_BASE+1, WR_WRAP=0, three results -> writes at 4096 and 4097. Then wr_full=1, third ack with no go, and wr_ovf=1.
//  4. RD_BASE=0, RD_LIMIT=1, src_words=3 -> read addresses 0,1,0.
//  5. TIMEOUT=4, mem_done held low -> go once, back to IDLE after 4 WAIT cycles, timeout_err=1. Retry at the same address succeeds.
//  6. rst asserted in RD_WAIT -> next cycle all outputs 0, rd_ptr=RD_BASE; a late mem_done is ignored.

Source files
------------

// File: rtl/dsec_mem_sequencer.sv
// dsec_mem_sequencer: moves source words from a read ring into the DSEC core
// and stores DSEC results into a write ring, one memory access at a time.
// Every access is a go strobe followed by a wait for mem_done. A missing
// mem_done is abandoned after TIMEOUT wait cycles, and the access is retried
// on a later grant.
module dsec_mem_sequencer #(
    parameter int ADDR_W   = 13,
    parameter int RD_BASE  = 0,
    parameter int RD_LIMIT = 4095,
    parameter int WR_BASE  = 4096,
    parameter int WR_LIMIT = 8191,
    parameter int WR_WRAP  = 0,
    parameter int ARB_RR   = 0,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic [ADDR_W:0]   src_words,
    output logic [ADDR_W-1:0] address,
    output logic              w_rn,
    output logic              go,
    input  logic              mem_done,
    input  logic              dsec_rdy,
    output logic              dsec_in_valid,
    input  logic              dsec_out_valid,
    output logic              dsec_out_ack,
    output logic              rd_done,
    output logic              wr_full,
    output logic              wr_ovf,
    output logic              timeout_err
);

    localparam int TMO_W = $clog2(TIMEOUT);
    localparam logic [ADDR_W-1:0] RD_BASE_A  = ADDR_W'(RD_BASE);
    localparam logic [ADDR_W-1:0] RD_LIMIT_A = ADDR_W'(RD_LIMIT);
    localparam logic [ADDR_W-1:0] WR_BASE_A  = ADDR_W'(WR_BASE);
    localparam logic [ADDR_W-1:0] WR_LIMIT_A = ADDR_W'(WR_LIMIT);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} state_t;

    state_t            state, state_d;
    logic [ADDR_W-1:0] rd_ptr, wr_ptr;
    logic [ADDR_W:0]   rd_cnt, rd_cnt_d, src_q, src_d;
    logic [TMO_W-1:0]  tmo_cnt;
    logic              last_wr;

    logic              in_idle, in_wait, clr_idle;
    logic              wr_req, rd_req, grant_wr, grant_rd, drop;
    logic              rd_fin, wr_fin, tmo_hit;

    logic [ADDR_W-1:0] address_d;
    logic              go_d, w_rn_d, in_valid_d, ack_d;

    // Request decode, arbitration and access-completion events.
    always_comb begin
        in_idle  = (state == IDLE);
        in_wait  = (state == RD_WAIT) || (state == WR_WAIT);
        clr_idle = in_idle && clr;
        // A result is masked while its ack is on the wire: DSEC still shows
        // the old word that cycle, and granting it again would store it twice.
        wr_req   = dsec_out_valid && !wr_full && !dsec_out_ack;
        rd_req   = dsec_rdy && (rd_cnt < src_words);
        grant_wr = in_idle && !clr && wr_req &&
                   (!rd_req || (ARB_RR == 0) || !last_wr);
        grant_rd = in_idle && !clr && rd_req && !grant_wr;
        drop     = in_idle && !clr && dsec_out_valid && wr_full && !dsec_out_ack;
        rd_fin   = (state == RD_WAIT) && mem_done;
        wr_fin   = (state == WR_WAIT) && mem_done;
        tmo_hit  = in_wait && !mem_done && (tmo_cnt == TMO_W'(TIMEOUT - 1));
        rd_cnt_d = clr_idle ? '0 : (rd_fin ? rd_cnt + (ADDR_W + 1)'(1) : rd_cnt);
        src_d    = in_idle ? src_words : src_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, whatever the statement order.
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default first, so no path through the case leaves state_d
        // unassigned and infers a latch.
        state_d = state;
        case (state)
            IDLE:    if (grant_wr)               state_d = WR_REQ;
                     else if (grant_rd)          state_d = RD_REQ;
            RD_REQ:                              state_d = RD_WAIT;
            RD_WAIT: if (mem_done || tmo_hit)    state_d = IDLE;
            WR_REQ:                              state_d = WR_WAIT;
            WR_WAIT: if (mem_done || tmo_hit)    state_d = IDLE;
            default:                             state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state; registered below.
    always_comb begin
        go_d       = (state_d == RD_REQ) || (state_d == WR_REQ);
        w_rn_d     = (state_d == WR_REQ) || (state_d == WR_WAIT);
        in_valid_d = rd_fin;
        ack_d      = wr_fin || drop;
        case (state_d)
            RD_REQ, RD_WAIT: address_d = rd_ptr;
            WR_REQ, WR_WAIT: address_d = wr_ptr;
            default:         address_d = '0;
        endcase
    end

    // Memory bus and DSEC strobe registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            address       <= '0;
            w_rn          <= 1'b0;
            go            <= 1'b0;
            dsec_in_valid <= 1'b0;
            dsec_out_ack  <= 1'b0;
        end else begin
            address       <= address_d;
            w_rn          <= w_rn_d;
            go            <= go_d;
            dsec_in_valid <= in_valid_d;
            dsec_out_ack  <= ack_d;
        end
    end

    // Ring pointers, read budget, timeout counter and sticky flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr      <= RD_BASE_A;
            wr_ptr      <= WR_BASE_A;
            rd_cnt      <= '0;
            src_q       <= '0;
            rd_done     <= 1'b0;
            tmo_cnt     <= '0;
            last_wr     <= 1'b0;
            wr_full     <= 1'b0;
            wr_ovf      <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            rd_cnt  <= rd_cnt_d;
            rd_done <= (rd_cnt_d == src_d);
            if (in_idle) src_q <= src_words;
            tmo_cnt <= (in_wait && !mem_done && !tmo_hit) ? tmo_cnt + TMO_W'(1) : '0;
            if (grant_wr)      last_wr <= 1'b1;
            else if (grant_rd) last_wr <= 1'b0;

            if (clr_idle) begin
                rd_ptr      <= RD_BASE_A;
                wr_ptr      <= WR_BASE_A;
                wr_full     <= 1'b0;
                wr_ovf      <= 1'b0;
                timeout_err <= 1'b0;
            end else begin
                if (rd_fin)
                    rd_ptr <= (rd_ptr == RD_LIMIT_A) ? RD_BASE_A : rd_ptr + ADDR_W'(1);
                if (wr_fin) begin
                    if (wr_ptr != WR_LIMIT_A) wr_ptr  <= wr_ptr + ADDR_W'(1);
                    else if (WR_WRAP != 0)    wr_ptr  <= WR_BASE_A;
                    else                      wr_full <= 1'b1;
                end
                if (drop)    wr_ovf      <= 1'b1;
                if (tmo_hit) timeout_err <= 1'b1;
            end
        end
    end

endmodule
